// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: depth, tag/preg widths and the entry layout.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = 5;
    localparam int IDX_W     = 4;
    localparam int PREG_W    = 7;
    localparam int PC_W      = 32;
    localparam int CTR_W     = 5;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [CTR_W-1:0]  ctr_t;

    typedef struct packed {
        logic            valid;
        logic            complete;
        preg_t           pd_new;
        preg_t           pd_old;
        logic [PC_W-1:0] pc;
    } rob_entry_t;

    // Distance of an index from the head; larger means younger in program order.
    function automatic idx_t age_of(input idx_t idx, input idx_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate/retire, out-of-order
// completion from three FUs, and squash of everything younger than a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        write_en,
    input  logic [6:0]  pd_new_in,
    input  logic [6:0]  pd_old_in,
    input  logic [31:0] pc_in,
    input  logic        fu_alu_done,
    input  logic        fu_b_done,
    input  logic        fu_mem_done,
    input  logic [4:0]  rob_fu_alu,
    input  logic [4:0]  rob_fu_b,
    input  logic [4:0]  rob_fu_mem,
    input  logic        br_mispredict,
    input  logic [4:0]  br_mispredict_tag,
    output logic [6:0]  preg_old,
    output logic        valid_retired,
    output logic        mispredict,
    output logic [4:0]  mispredict_tag,
    output logic        full,
    output logic [4:0]  ptr
);

    // Strobe semantics: write_en is accepted only when full is low (no stall
    // back-pressure beyond full); valid_retired and mispredict are one-cycle
    // pulses with their payload (preg_old / mispredict_tag) valid in the same cycle.

    rob_entry_t           entries [ROB_DEPTH];
    idx_t                 head;
    idx_t                 tail;
    ctr_t                 ctr;

    logic                 retire;
    logic                 alloc;
    idx_t                 head_next;
    idx_t                 br_idx;
    logic [ROB_DEPTH-1:0] kill;
    logic [ROB_DEPTH-1:0] done_vec;
    logic                 unused_bits;

    assign full      = (ctr == CTR_W'(ROB_DEPTH));
    assign ptr       = {1'b0, tail};
    assign retire    = entries[head].valid && entries[head].complete;
    // A flush in the same cycle wins over a new allocation.
    assign alloc     = write_en && !full && !br_mispredict;
    assign head_next = head + idx_t'(retire);
    assign br_idx    = br_mispredict_tag[IDX_W-1:0];

    assign unused_bits = ^{br_mispredict_tag[TAG_W-1], entries[head].pd_new, entries[head].pc};

    always_comb begin
        kill     = '0;
        done_vec = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            // Age relative to the current head separates older from younger entries.
            kill[i]     = br_mispredict &&
                          (age_of(idx_t'(i), head) > age_of(br_idx, head));
            done_vec[i] = (fu_alu_done && rob_fu_alu == TAG_W'(i)) ||
                          (fu_b_done   && rob_fu_b   == TAG_W'(i)) ||
                          (fu_mem_done && rob_fu_mem == TAG_W'(i));
        end
    end

    // Entry storage; later assignments take priority (a squash overrides completion).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (done_vec[i] && entries[i].valid) begin
                    entries[i].complete <= 1'b1;
                end
                if (retire && idx_t'(i) == head) begin
                    entries[i].valid <= 1'b0;
                end
                if (alloc && idx_t'(i) == tail) begin
                    entries[i].valid    <= 1'b1;
                    entries[i].complete <= 1'b0;
                    entries[i].pd_new   <= pd_new_in;
                    entries[i].pd_old   <= pd_old_in;
                    entries[i].pc       <= pc_in;
                end
                if (kill[i]) begin
                    entries[i].valid    <= 1'b0;
                    entries[i].complete <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            ctr  <= '0;
        end else begin
            head <= head_next;
            if (br_mispredict) begin
                tail <= br_idx + idx_t'(1);
                ctr  <= CTR_W'(idx_t'(br_idx - head_next)) + CTR_W'(1);
            end else begin
                if (alloc) begin
                    tail <= tail + idx_t'(1);
                end
                ctr <= ctr + CTR_W'(alloc) - CTR_W'(retire);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preg_old       <= '0;
            valid_retired  <= 1'b0;
            mispredict     <= 1'b0;
            mispredict_tag <= '0;
        end else begin
            valid_retired <= retire;
            if (retire) begin
                preg_old <= entries[head].pd_old;
            end
            mispredict <= br_mispredict;
            if (br_mispredict) begin
                mispredict_tag <= br_mispredict_tag;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: retirements are checked against an
// expected queue of pd_old values in program order.
module tb_reorder_buffer;

    logic        clk;
    logic        reset;
    logic        write_en;
    logic [6:0]  pd_new_in;
    logic [6:0]  pd_old_in;
    logic [31:0] pc_in;
    logic        fu_alu_done;
    logic        fu_b_done;
    logic        fu_mem_done;
    logic [4:0]  rob_fu_alu;
    logic [4:0]  rob_fu_b;
    logic [4:0]  rob_fu_mem;
    logic        br_mispredict;
    logic [4:0]  br_mispredict_tag;
    logic [6:0]  preg_old;
    logic        valid_retired;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        full;
    logic [4:0]  ptr;

    logic [6:0] exp_q[$];
    int total;
    int bad;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .write_en          (write_en),
        .pd_new_in         (pd_new_in),
        .pd_old_in         (pd_old_in),
        .pc_in             (pc_in),
        .fu_alu_done       (fu_alu_done),
        .fu_b_done         (fu_b_done),
        .fu_mem_done       (fu_mem_done),
        .rob_fu_alu        (rob_fu_alu),
        .rob_fu_b          (rob_fu_b),
        .rob_fu_mem        (rob_fu_mem),
        .br_mispredict     (br_mispredict),
        .br_mispredict_tag (br_mispredict_tag),
        .preg_old          (preg_old),
        .valid_retired     (valid_retired),
        .mispredict        (mispredict),
        .mispredict_tag    (mispredict_tag),
        .full              (full),
        .ptr               (ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    // driver tasks
    task automatic do_alloc(input logic [6:0] pdo, input bit accept);
        write_en  = 1'b1;
        pd_old_in = pdo;
        pd_new_in = pdo ^ 7'h40;
        pc_in     = 32'h1000 + {25'd0, pdo};
        if (accept) exp_q.push_back(pdo);
        step();
        write_en = 1'b0;
    endtask

    task automatic do_complete(input int fu, input logic [4:0] tag);
        case (fu)
            0:       begin fu_alu_done = 1'b1; rob_fu_alu = tag; end
            1:       begin fu_b_done   = 1'b1; rob_fu_b   = tag; end
            default: begin fu_mem_done = 1'b1; rob_fu_mem = tag; end
        endcase
        step();
        fu_alu_done = 1'b0;
        fu_b_done   = 1'b0;
        fu_mem_done = 1'b0;
    endtask

    task automatic do_mispredict(input logic [4:0] tag, input int flushed);
        br_mispredict     = 1'b1;
        br_mispredict_tag = tag;
        for (int i = 0; i < flushed; i++) void'(exp_q.pop_back());
        step();
        br_mispredict = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && valid_retired) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got preg_old 0x%0h with nothing expected", preg_old);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if (preg_old !== e) begin
                    bad++;
                    $display("FAIL retire_order: got preg_old 0x%0h expected 0x%0h", preg_old, e);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        write_en = 0; pd_new_in = 0; pd_old_in = 0; pc_in = 0;
        fu_alu_done = 0; fu_b_done = 0; fu_mem_done = 0;
        rob_fu_alu = 0; rob_fu_b = 0; rob_fu_mem = 0;
        br_mispredict = 0; br_mispredict_tag = 0;
        apply_reset();

        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_ptr", {27'd0, ptr}, 32'd0);
        check("reset_ctr", {27'd0, dut.ctr}, 32'd0);
        check("reset_valid_retired", {31'd0, valid_retired}, 32'd0);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);

        // out-of-order complete, in-order retire
        do_alloc(7'h10, 1);
        do_alloc(7'h11, 1);
        do_alloc(7'h12, 1);
        check("ooo_ptr", {27'd0, ptr}, 32'd3);
        do_complete(0, 5'd1);
        step();
        check("ooo_no_retire", {31'd0, valid_retired}, 32'd0);
        do_complete(1, 5'd0);
        step();
        check("ooo_retire0", {25'd0, valid_retired, preg_old}, {25'd0, 1'b1, 7'h10});
        step();
        check("ooo_retire1", {25'd0, valid_retired, preg_old}, {25'd0, 1'b1, 7'h11});
        do_complete(2, 5'd2);
        check("ooo_gap", {31'd0, valid_retired}, 32'd0);
        step();
        step();
        check("ooo_ctr_empty", {27'd0, dut.ctr}, 32'd0);

        // head mispredict
        do_alloc(7'h20, 1);
        do_alloc(7'h21, 1);
        do_alloc(7'h22, 1);
        do_complete(0, 5'd5);
        step();
        check("headmp_no_retire", {31'd0, valid_retired}, 32'd0);
        do_mispredict(5'd3, 2);
        check("headmp_flag", {31'd0, mispredict}, 32'd1);
        check("headmp_tag", {27'd0, mispredict_tag}, 32'd3);
        check("headmp_ptr", {27'd0, ptr}, 32'd4);
        check("headmp_ctr", {27'd0, dut.ctr}, 32'd1);
        step();
        check("headmp_flag_clear", {31'd0, mispredict}, 32'd0);
        do_complete(2, 5'd3);
        step();
        check("headmp_ptr_reuse", {27'd0, ptr}, 32'd4);
        do_alloc(7'h23, 1);
        check("headmp_alloc_ptr", {27'd0, ptr}, 32'd5);
        do_complete(1, 5'd4);
        step();
        step();
        check("headmp_ctr_empty", {27'd0, dut.ctr}, 32'd0);

        // wrap / full: head and tail sit at 5
        for (int i = 0; i < 16; i++) do_alloc(7'h40 + 7'(i), 1);
        check("wrap_full", {31'd0, full}, 32'd1);
        check("wrap_ctr16", {27'd0, dut.ctr}, 32'd16);
        check("wrap_ptr", {27'd0, ptr}, 32'd5);
        do_alloc(7'h7f, 0);
        check("wrap_ignored_alloc", {27'd0, dut.ctr}, 32'd16);
        fu_alu_done = 1'b1; rob_fu_alu = 5'd5;
        fu_b_done   = 1'b1; rob_fu_b   = 5'd6;
        step();
        fu_alu_done = 1'b0; fu_b_done = 1'b0;
        step();
        step();
        check("wrap_not_full", {31'd0, full}, 32'd0);
        check("wrap_ctr14", {27'd0, dut.ctr}, 32'd14);
        do_alloc(7'h60, 1);
        check("wrap_alloc_after", {27'd0, dut.ctr}, 32'd15);
        check("wrap_alloc_ptr", {27'd0, ptr}, 32'd6);

        // asynchronous reset mid-operation
        reset = 1'b1;
        #1;
        check("async_reset_ctr", {27'd0, dut.ctr}, 32'd0);
        check("async_reset_ptr", {27'd0, ptr}, 32'd0);
        apply_reset();

        // mid-buffer mispredict
        do_alloc(7'h50, 1);
        do_alloc(7'h51, 1);
        do_alloc(7'h52, 1);
        do_alloc(7'h53, 1);
        do_complete(2, 5'd3);
        do_mispredict(5'd2, 1);
        check("midmp_ctr", {27'd0, dut.ctr}, 32'd3);
        check("midmp_tag", {27'd0, mispredict_tag}, 32'd2);
        do_complete(0, 5'd0);
        do_complete(1, 5'd1);
        do_complete(2, 5'd2);
        step();
        step();
        check("midmp_ctr_empty", {27'd0, dut.ctr}, 32'd0);
        check("midmp_next_tag", {27'd0, ptr}, 32'd3);

        // free-list sequence
        do_alloc(7'h31, 1);
        do_alloc(7'h32, 1);
        do_alloc(7'h33, 1);
        do_complete(0, 5'd3);
        step();
        check("free_31", {25'd0, valid_retired, preg_old}, {25'd0, 1'b1, 7'h31});
        do_complete(1, 5'd4);
        step();
        check("free_32", {25'd0, valid_retired, preg_old}, {25'd0, 1'b1, 7'h32});
        do_complete(2, 5'd5);
        step();
        check("free_33", {25'd0, valid_retired, preg_old}, {25'd0, 1'b1, 7'h33});
        step();
        check("free_idle_hold", {25'd0, valid_retired, preg_old}, {25'd0, 1'b0, 7'h33});

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
